// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   rdOwnerT             : who owns the read data returning from memory this cycle
//   STARVE_LIMIT_DEFAULT : default number of lost auxiliary cycles before the
//                          auxiliary port is forced a grant (fair mode only)
// Optional feature macro used by the arbiter: DMEM_ARB_FAIR_EN
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } rdOwnerT;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Saturating counter that tracks how many consecutive cycles the auxiliary
// port lost arbitration. When the count reaches LIMIT, forceOut is raised so
// the arbiter hands the next grant to the auxiliary port.
// Only instantiated when DMEM_ARB_FAIR_EN is defined.
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : synchronous, active-high; clears the count
//   inc      in  : auxiliary lost a contended cycle
//   clear    in  : auxiliary was granted; restart the count
//   forceOut out : count has reached LIMIT
// ---------------------------------------------------------------------------
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic forceOut
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LimitVal = CW'(LIMIT);

  logic [CW-1:0] count;

  // Clear wins over increment; the count holds once it reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LimitVal)) begin
      count <= count + CW'(1);
    end
  end

  assign forceOut = (count == LimitVal);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU memory stage and an
// auxiliary (debug / program loader) port. One access is granted per cycle,
// the loser is stalled, and synchronous-read data (1-cycle latency) is routed
// back to whichever requester issued the load.
// Optional feature macro: DMEM_ARB_FAIR_EN
//   defined     : starvation guard forces an auxiliary grant after
//                 STARVE_LIMIT consecutive lost contended cycles
//   not defined : CPU has strict priority
// Ports:
//   clk, reset                       : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata            : CPU request (level, held until accepted)
//   cpu_stall                        : CPU request not accepted this cycle
//   cpu_rvalid/cpu_rdata             : CPU load data, one cycle after grant
//   aux_req/we/addr/wdata            : auxiliary request, same semantics
//   aux_gnt                          : auxiliary request accepted this cycle
//   aux_rvalid/aux_rdata             : auxiliary load data, one cycle after grant
//   mem_addr/mem_we/mem_wdata        : data-memory bus (word address)
//   mem_rdata                        : memory read data, valid one cycle later
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DBITS               = 32,
  parameter int DMEM_ADDR_BITS_HI   = 13,
  parameter int DMEM_ADDR_BITS_LO   = 2,
  parameter int DMEM_ADDR_BIT_WIDTH = 11,
  parameter int STARVE_LIMIT        = dmem_arb_pkg::STARVE_LIMIT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [DBITS-1:0]               cpu_addr,
  input  logic [DBITS-1:0]               cpu_wdata,
  output logic                           cpu_stall,
  output logic                           cpu_rvalid,
  output logic [DBITS-1:0]               cpu_rdata,
  input  logic                           aux_req,
  input  logic                           aux_we,
  input  logic [DBITS-1:0]               aux_addr,
  input  logic [DBITS-1:0]               aux_wdata,
  output logic                           aux_gnt,
  output logic                           aux_rvalid,
  output logic [DBITS-1:0]               aux_rdata,
  output logic [DMEM_ADDR_BIT_WIDTH-1:0] mem_addr,
  output logic                           mem_we,
  output logic [DBITS-1:0]               mem_wdata,
  input  logic [DBITS-1:0]               mem_rdata
);

  import dmem_arb_pkg::*;

  logic    forceAux;
  logic    cpuGnt;
  rdOwnerT rdOwner;
  rdOwnerT rdOwnerNext;

  // Address bits outside the word slice are deliberately ignored, so
  // addresses wrap modulo the memory size.
  logic unusedAddr;
  assign unusedAddr = ^{cpu_addr, aux_addr};

`ifdef DMEM_ARB_FAIR_EN
  logic starveInc;

  // A contended cycle the auxiliary port loses counts towards starvation.
  assign starveInc = aux_req & cpu_req & ~forceAux;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) uStarveCounter (
    .clk      (clk),
    .reset    (reset),
    .inc      (starveInc),
    .clear    (aux_gnt),
    .forceOut (forceAux)
  );
`else
  logic [31:0] unusedLimit;
  assign unusedLimit = 32'(STARVE_LIMIT);
  assign forceAux    = 1'b0;
`endif

  // Same-cycle grant decision: CPU wins a contended cycle unless the
  // starvation guard is forcing the auxiliary port through.
  assign cpuGnt    = cpu_req & ~forceAux;
  assign aux_gnt   = aux_req & (~cpu_req | forceAux);
  assign cpu_stall = cpu_req & ~cpuGnt;

  // Drive the memory bus from the granted requester; an idle bus is all zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpuGnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[DMEM_ADDR_BITS_HI-1:DMEM_ADDR_BITS_LO];
      mem_wdata = cpu_wdata;
    end else if (aux_gnt) begin
      mem_we    = aux_we;
      mem_addr  = aux_addr[DMEM_ADDR_BITS_HI-1:DMEM_ADDR_BITS_LO];
      mem_wdata = aux_wdata;
    end
  end

  // Read-owner register: remembers who issued the load whose data the
  // memory returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdOwner <= OWN_NONE;
    end else begin
      rdOwner <= rdOwnerNext;
    end
  end

  // Only granted loads claim the returning read data; stores and idle
  // cycles leave the next cycle unowned.
  always_comb begin
    rdOwnerNext = OWN_NONE;
    if (cpuGnt && !cpu_we) begin
      rdOwnerNext = OWN_CPU;
    end else if (aux_gnt && !aux_we) begin
      rdOwnerNext = OWN_AUX;
    end
  end

  // Return path. Gating with reset means a reset raised in the cycle after
  // a load grant hides that load's data immediately, not one cycle later.
  always_comb begin
    cpu_rvalid = (rdOwner == OWN_CPU) && !reset;
    aux_rvalid = (rdOwner == OWN_AUX) && !reset;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    aux_rdata  = aux_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural synchronous-read
// data memory. Expectations follow DMEM_ARB_FAIR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] aux_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] memRdata;

  logic [31:0] memArr [0:2047];

  int totalChecks = 0;
  int passChecks  = 0;

  // ctl = {cpuReq, cpuWe, auxReq, auxWe}; expCtl = {cpu_stall, aux_gnt, mem_we};
  // expRv = {cpu_rvalid, aux_rvalid}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWdata;
    logic [31:0] auxAddr;
    logic [31:0] auxWdata;
    logic [2:0]  expCtl;
    logic [10:0] expMemAddr;
    logic [31:0] expMemWdata;
    logic [1:0]  expRv;
    logic [31:0] expCpuRdata;
    logic [31:0] expAuxRdata;
  } vectorT;

  vectorT vecs [0:16];

  always #5 clk = ~clk;

  // Behavioural data memory: write at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr] <= mem_wdata;
    memRdata <= memArr[mem_addr];
  end

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (memRdata)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vectorT v);
    {cpu_req, cpu_we, aux_req, aux_we} = v.ctl;
    cpu_addr  = v.cpuAddr;
    cpu_wdata = v.cpuWdata;
    aux_addr  = v.auxAddr;
    aux_wdata = v.auxWdata;
  endtask

  task automatic applyIdle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end else begin
      passChecks++;
    end
  endtask

  initial begin
    logic expAux;
    logic prevAux;

    for (int a = 0; a < 2048; a++) memArr[a] = 32'h0;
    memArr[4] = 32'hDEAD_BEEF;
    memArr[5] = 32'h1111_1111;
    memArr[6] = 32'h2222_2222;
    memArr[7] = 32'h3333_3333;

    vecs[0]  = '{4'b0000, 32'h0,    32'h0,    32'h0,  32'h0,    3'b000, 11'd0,  32'h0,    2'b00, 32'h0,         32'h0};
    vecs[1]  = '{4'b1000, 32'h10,   32'h0,    32'h0,  32'h0,    3'b000, 11'd4,  32'h0,    2'b00, 32'h0,         32'h0};
    vecs[2]  = '{4'b0011, 32'h0,    32'h0,    32'h20, 32'h1234, 3'b011, 11'd8,  32'h1234, 2'b10, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{4'b1000, 32'h20,   32'h0,    32'h0,  32'h0,    3'b000, 11'd8,  32'h0,    2'b00, 32'h0,         32'h0};
    vecs[4]  = '{4'b1000, 32'h14,   32'h0,    32'h0,  32'h0,    3'b000, 11'd5,  32'h0,    2'b10, 32'h1234,      32'h0};
    vecs[5]  = '{4'b0010, 32'h0,    32'h0,    32'h18, 32'h0,    3'b010, 11'd6,  32'h0,    2'b10, 32'h1111_1111, 32'h0};
    vecs[6]  = '{4'b1000, 32'h801C, 32'h0,    32'h0,  32'h0,    3'b000, 11'd7,  32'h0,    2'b01, 32'h0,         32'h2222_2222};
    vecs[7]  = '{4'b0000, 32'h0,    32'h0,    32'h0,  32'h0,    3'b000, 11'd0,  32'h0,    2'b10, 32'h3333_3333, 32'h0};
    vecs[8]  = '{4'b1100, 32'h2010, 32'hCAFE, 32'h0,  32'h0,    3'b001, 11'd4,  32'hCAFE, 2'b00, 32'h0,         32'h0};
    vecs[9]  = '{4'b1000, 32'h10,   32'h0,    32'h0,  32'h0,    3'b000, 11'd4,  32'h0,    2'b00, 32'h0,         32'h0};
    vecs[10] = '{4'b0000, 32'h0,    32'h0,    32'h0,  32'h0,    3'b000, 11'd0,  32'h0,    2'b10, 32'hCAFE,      32'h0};
    vecs[11] = '{4'b1010, 32'h14,   32'h0,    32'h18, 32'h77,   3'b000, 11'd5,  32'h0,    2'b00, 32'h0,         32'h0};
    vecs[12] = '{4'b0000, 32'h0,    32'h0,    32'h0,  32'h0,    3'b000, 11'd0,  32'h0,    2'b10, 32'h1111_1111, 32'h0};
    vecs[13] = '{4'b0111, 32'h30,   32'h55,   32'h3C, 32'h99,   3'b011, 11'd15, 32'h99,   2'b00, 32'h0,         32'h0};
    vecs[14] = '{4'b0010, 32'h0,    32'h0,    32'h3C, 32'h0,    3'b010, 11'd15, 32'h0,    2'b00, 32'h0,         32'h0};
    vecs[15] = '{4'b1110, 32'h40,   32'hAB,   32'h3C, 32'h0,    3'b001, 11'd16, 32'hAB,   2'b01, 32'h0,         32'h99};
    vecs[16] = '{4'b0000, 32'h0,    32'h0,    32'h0,  32'h0,    3'b000, 11'd0,  32'h0,    2'b00, 32'h0,         32'h0};

    // Reset state.
    reset = 1'b1;
    applyIdle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("reset aux_rvalid", 32'(aux_rvalid), 32'h0);
    checkOutput("reset cpu_rdata",  cpu_rdata, 32'h0);
    checkOutput("reset aux_rdata",  aux_rdata, 32'h0);
    checkOutput("reset mem_we",     32'(mem_we), 32'h0);

    // Directed vector table.
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) nextCycle();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),  32'(vecs[i].expCtl[2]));
      checkOutput($sformatf("v%0d aux_gnt", i),    32'(aux_gnt),    32'(vecs[i].expCtl[1]));
      checkOutput($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vecs[i].expCtl[0]));
      checkOutput($sformatf("v%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].expMemAddr));
      checkOutput($sformatf("v%0d mem_wdata", i),  mem_wdata,       vecs[i].expMemWdata);
      checkOutput($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].expRv[1]));
      checkOutput($sformatf("v%0d aux_rvalid", i), 32'(aux_rvalid), 32'(vecs[i].expRv[0]));
      checkOutput($sformatf("v%0d cpu_rdata", i),  cpu_rdata,       vecs[i].expCpuRdata);
      checkOutput($sformatf("v%0d aux_rdata", i),  aux_rdata,       vecs[i].expAuxRdata);
    end

    // Continuous contention: CPU loads word 4, aux loads word 6.
    nextCycle();
    reset = 1'b1;
    applyIdle();
    nextCycle();
    reset    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    aux_req  = 1'b1;
    aux_addr = 32'h18;
    prevAux  = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) nextCycle();
      @(negedge clk);
`ifdef DMEM_ARB_FAIR_EN
      expAux = ((k % 5) == 4);
`else
      expAux = 1'b0;
`endif
      checkOutput($sformatf("contend%0d aux_gnt", k),   32'(aux_gnt),   32'(expAux));
      checkOutput($sformatf("contend%0d cpu_stall", k), 32'(cpu_stall), 32'(expAux));
      checkOutput($sformatf("contend%0d mem_addr", k),  32'(mem_addr),  expAux ? 32'd6 : 32'd4);
      if (k > 0) begin
        checkOutput($sformatf("contend%0d cpu_rvalid", k), 32'(cpu_rvalid), 32'(!prevAux));
        checkOutput($sformatf("contend%0d aux_rvalid", k), 32'(aux_rvalid), 32'(prevAux));
        checkOutput($sformatf("contend%0d cpu_rdata", k),  cpu_rdata, prevAux ? 32'h0 : 32'hCAFE);
        checkOutput($sformatf("contend%0d aux_rdata", k),  aux_rdata, prevAux ? 32'h2222_2222 : 32'h0);
      end
      prevAux = expAux;
    end

    // Load granted, then reset in the following cycle with a store pending.
    nextCycle();
    applyIdle();
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    aux_req  = 1'b1;
    aux_addr = 32'h18;
    @(negedge clk);
    checkOutput("rst load cpu_stall", 32'(cpu_stall), 32'h0);
    checkOutput("rst load mem_addr",  32'(mem_addr),  32'd4);
    nextCycle();
    reset     = 1'b1;
    aux_req   = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h44;
    cpu_wdata = 32'hEE;
    @(negedge clk);
    checkOutput("rst cycle cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("rst cycle cpu_rdata",  cpu_rdata, 32'h0);
    checkOutput("rst cycle mem_we",     32'(mem_we), 32'h1);
    checkOutput("rst cycle mem_addr",   32'(mem_addr), 32'd17);
    checkOutput("rst cycle mem_wdata",  mem_wdata, 32'hEE);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("rst hold cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("rst hold aux_rvalid", 32'(aux_rvalid), 32'h0);
    nextCycle();
    reset    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h10;
    aux_req  = 1'b1;
    aux_addr = 32'h18;
    @(negedge clk);
    checkOutput("post rst cpu_stall",  32'(cpu_stall),  32'h0);
    checkOutput("post rst aux_gnt",    32'(aux_gnt),    32'h0);
    checkOutput("post rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    checkOutput("post rst aux_rvalid", 32'(aux_rvalid), 32'h0);
    nextCycle();
    aux_req  = 1'b0;
    cpu_addr = 32'h44;
    @(negedge clk);
    checkOutput("post rst load cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    checkOutput("post rst load cpu_rdata",  cpu_rdata, 32'hCAFE);
    nextCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("store under rst cpu_rdata", cpu_rdata, 32'hEE);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
